// File: rtl/spi_master_ctrl.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI master with programmable SS lead, trail and gap timing.
// Every output comes straight from a flop; MISO passes through a 2-flop synchroniser.
module spi_master_ctrl #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 4,
    parameter int SS_LEAD  = 4,
    parameter int SS_TRAIL = 4,
    parameter int SS_GAP   = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              SCK,
    output logic              MOSI,
    output logic              SS,
    input  logic              MISO
);
    // state | meaning
    // IDLE  | ready for a word, SS high
    // LEAD  | SS low, SCK low, MSB on MOSI, waiting SS_LEAD cycles
    // SHIFT | DATA_W bits of HALF_DIV low + HALF_DIV high SCK
    // TRAIL | SS still low after the last fall, SS_TRAIL cycles
    // GAP   | SS high, word delivered, SS_GAP cycles before IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP
    } state_t;

    localparam int CNT_W = 16;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LEAD  = CNT_W'(SS_LEAD - 1);
    localparam logic [CNT_W-1:0] C_HALF  = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] C_TRAIL = CNT_W'(SS_TRAIL - 1);
    localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] C_LAST  = BIT_W'(DATA_W - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_div, w_div_nxt;
    logic [BIT_W-1:0]    r_bit, w_bit_nxt;
    logic [DATA_W-1:0]   r_tx_sr, w_tx_sr_nxt;
    logic [DATA_W-1:0]   r_rx_sr, w_rx_sr_nxt;
    logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic                r_rx_valid, w_rx_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_tx_ready, w_tx_ready_nxt;
    logic                r_sck, w_sck_nxt;
    logic                r_ss, w_ss_nxt;
    logic                r_miso_meta, r_miso_sync;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_sck       <= 1'b0;
            r_ss        <= 1'b1;
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_tx_sr     <= w_tx_sr_nxt;
            r_rx_sr     <= w_rx_sr_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_sck       <= w_sck_nxt;
            r_ss        <= w_ss_nxt;
            r_miso_meta <= MISO;
            r_miso_sync <= r_miso_meta;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_bit_nxt      = r_bit;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_tx_ready_nxt = r_tx_ready;
        w_sck_nxt      = r_sck;
        w_ss_nxt       = r_ss;
        case (r_state)
            S_IDLE: begin
                if (tx_valid_i && r_tx_ready) begin
                    w_state_nxt    = S_LEAD;
                    w_div_nxt      = C_LEAD;
                    w_bit_nxt      = '0;
                    w_tx_sr_nxt    = tx_data_i;
                    w_ss_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_tx_ready_nxt = 1'b0;
                end
            end
            S_LEAD: begin
                if (r_div == '0) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = C_HALF;
                end else begin
                    w_div_nxt = r_div - CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (r_div == '0) begin
                    w_div_nxt = C_HALF;
                    w_sck_nxt = ~r_sck;
                    // Falling edge: capture MISO late in the high phase, then present the next bit.
                    if (r_sck) begin
                        w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], r_miso_sync};
                        if (r_bit == C_LAST) begin
                            w_state_nxt = S_TRAIL;
                            w_div_nxt   = C_TRAIL;
                        end else begin
                            w_tx_sr_nxt = {r_tx_sr[DATA_W-2:0], 1'b0};
                            w_bit_nxt   = r_bit + BIT_W'(1);
                        end
                    end
                end else begin
                    w_div_nxt = r_div - CNT_W'(1);
                end
            end
            S_TRAIL: begin
                if (r_div == '0) begin
                    w_state_nxt    = S_GAP;
                    w_div_nxt      = C_GAP;
                    w_ss_nxt       = 1'b1;
                    w_rx_data_nxt  = r_rx_sr;
                    w_rx_valid_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_div == '0) begin
                    w_state_nxt    = S_IDLE;
                    w_busy_nxt     = 1'b0;
                    w_tx_ready_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_ss_nxt       = 1'b1;
                w_sck_nxt      = 1'b0;
                w_busy_nxt     = 1'b0;
                w_tx_ready_nxt = 1'b1;
            end
        endcase
    end

    assign tx_ready_o = r_tx_ready;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = r_busy;
    assign SCK        = r_sck;
    assign MOSI       = r_tx_sr[DATA_W-1];
    assign SS         = r_ss;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a frame-timeline reference model predicts every output per cycle,
// with directed frames pinned to hand-computed values and a randomized frame sequence.
module tb_spi_master_ctrl;
    localparam int D     = 8;
    localparam int H     = 4;
    localparam int L     = 4;
    localparam int T     = 4;
    localparam int G     = 4;
    localparam int FRAME = 1 + L + 2 * H * D + T + G;
    localparam int RXV_K = L + 2 * H * D + T;

    logic         clk = 1'b0;
    logic         reset_ni;
    logic [D-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready_o;
    logic [D-1:0] rx_data_o;
    logic         rx_valid_o;
    logic         busy_o;
    logic         SCK, MOSI, SS, MISO;

    // 0: loopback, 1: tied 0, 2: tied 1, 3: bench slave
    logic [1:0]   mode;
    logic [D-1:0] slave_word, slave_sr_out, slave_sr_in, slave_got;
    logic         slave_bit = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_prints = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .DATA_W(D), .HALF_DIV(H), .SS_LEAD(L), .SS_TRAIL(T), .SS_GAP(G)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .busy_o(busy_o), .SCK(SCK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
    );

    assign MISO = (mode == 2'd0) ? MOSI :
                  (mode == 2'd1) ? 1'b0 :
                  (mode == 2'd2) ? 1'b1 : slave_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_prints < 60) begin
                n_prints++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // Mode-0 slave: shifts out on SS fall / SCK fall, captures MOSI on SCK rise.
    always @(negedge SS) begin
        #1;
        slave_sr_out = slave_word;
        slave_bit    = slave_word[D-1];
    end
    always @(negedge SCK) begin
        if (!SS) begin
            #1;
            slave_sr_out = {slave_sr_out[D-2:0], 1'b0};
            slave_bit    = slave_sr_out[D-1];
        end
    end
    always @(posedge SCK) if (!SS) slave_sr_in = {slave_sr_in[D-2:0], MOSI};
    always @(posedge SS) slave_got = slave_sr_in;

    logic rises[$];
    always @(posedge SCK) rises.push_back(MOSI);

    // Reference model: a frame is a timeline indexed by k = cycles since the accept edge.
    logic         m_active = 1'b0;
    int           m_k = 0;
    logic [D-1:0] m_tx = '0, m_rx_exp = '0, m_rx_data = '0;
    logic         m_mosi_last = 1'b0;
    int           cyc = 0, m_acc_cycle = 0, m_accepts = 0;

    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_active    <= 1'b0;
            m_k         <= 0;
            m_mosi_last <= 1'b0;
            m_rx_data   <= '0;
        end else begin
            cyc <= cyc + 1;
            if (m_active) begin
                m_k <= m_k + 1;
                if (m_k + 1 == RXV_K) m_rx_data <= m_rx_exp;
                if (m_k + 1 == FRAME - 1) begin
                    m_active    <= 1'b0;
                    m_mosi_last <= m_tx[0];
                end
            end else if (tx_valid) begin
                m_active    <= 1'b1;
                m_k         <= 0;
                m_tx        <= tx_data;
                m_acc_cycle <= cyc + 1;
                m_accepts   <= m_accepts + 1;
                case (mode)
                    2'd0:    m_rx_exp <= tx_data;
                    2'd1:    m_rx_exp <= '0;
                    2'd2:    m_rx_exp <= '1;
                    default: m_rx_exp <= slave_word;
                endcase
            end
        end
    end

    logic         run_cmp = 1'b0;
    logic         e_ss, e_sck, e_mosi;
    int           j;
    int           last_lat = -1, n_rxv = 0;
    logic [D-1:0] last_rx = '0;

    always @(negedge clk) begin
        if (run_cmp) begin
            e_ss  = !(m_active && m_k < RXV_K);
            e_sck = m_active && m_k >= L && m_k < L + 2 * H * D && ((m_k - L) % (2 * H)) >= H;
            if (!m_active) e_mosi = m_mosi_last;
            else begin
                j = (m_k < L) ? 0 : (m_k - L) / (2 * H);
                if (j > D - 1) j = D - 1;
                e_mosi = m_tx[D-1-j];
            end
            chk("SS", SS, e_ss);
            chk("SCK", SCK, e_sck);
            chk("MOSI", MOSI, e_mosi);
            chk("busy", busy_o, m_active);
            chk("rx_valid", rx_valid_o, m_active && m_k == RXV_K);
            chk("rx_data", rx_data_o, m_rx_data);
            if (reset_ni) chk("tx_ready", tx_ready_o, !m_active);
            if (rx_valid_o === 1'b1) begin
                n_rxv++;
                last_lat = cyc - m_acc_cycle;
                last_rx  = rx_data_o;
            end
        end
    end

    task automatic send(input logic [D-1:0] d);
        int start;
        bit ok;
        #1;
        start    = m_accepts;
        tx_data  = d;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_accepts != start) begin
                ok = 1'b1;
                break;
            end
        end
        #1 tx_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m_active) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) chk("frame_timeout", 0, 1);
    endtask

    function automatic logic [D-1:0] rises_byte();
        logic [D-1:0] rb;
        rb = '0;
        for (int i = 0; i < rises.size(); i++) rb = {rb[D-2:0], rises[i]};
        return rb;
    endfunction

    initial begin
        logic         exp_a5 [8];
        logic [D-1:0] d, exp_rx;
        int           s, nr, ss_hi, rxv0;
        bit           ok;

        exp_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        reset_ni = 1'b0; tx_valid = 1'b0; tx_data = '0; mode = 2'd0; slave_word = '0;
        repeat (3) @(negedge clk);
        chk("rst_SS", SS, 1);
        chk("rst_SCK", SCK, 0);
        chk("rst_MOSI", MOSI, 0);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        run_cmp = 1'b1;
        #1 reset_ni = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", tx_ready_o, 1);

        // Loopback 0xA5: MOSI at each rise, latency, received word
        rises.delete();
        send(8'hA5);
        wait_done();
        chk("a5_rise_count", rises.size(), 8);
        for (int i = 0; i < 8 && i < rises.size(); i++) chk("a5_rise_mosi", rises[i], exp_a5[i]);
        chk("a5_latency", last_lat, 72);
        chk("a5_rx", last_rx, 8'hA5);

        // Slave attached: slave sees 0x3C, master receives slave's word
        mode = 2'd3; slave_word = 8'hC6;
        send(8'h3C);
        wait_done();
        chk("slave_got", slave_got, 8'h3C);
        chk("slave_rx", last_rx, 8'hC6);

        // MISO tied high / low
        mode = 2'd2;
        send(8'h00);
        wait_done();
        chk("miso1_rx", last_rx, 8'hFF);
        mode = 2'd1;
        send(8'hFF);
        wait_done();
        chk("miso0_rx", last_rx, 8'h00);

        // Back-to-back with tx_valid held high
        mode = 2'd0;
        rxv0 = n_rxv;
        #1;
        s = m_accepts;
        tx_data = 8'h01; tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_accepts != s) begin ok = 1'b1; break; end
        end
        if (!ok) chk("b2b_accept_timeout", 0, 1);
        nr = 0; ss_hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (!tx_ready_o) nr++;
            if (SS) ss_hi++;
            if (i == 0) #1 tx_data = 8'h80;
        end
        chk("b2b_ready_low", nr, 76);
        chk("b2b_ss_high_ge4", (ss_hi >= 4), 1);
        @(negedge clk);
        chk("b2b_second_accept", m_accepts - s, 2);
        #1 tx_valid = 1'b0;
        wait_done();
        chk("b2b_rx_count", n_rxv - rxv0, 2);
        chk("b2b_rx_last", last_rx, 8'h80);

        // tx_valid pulse while busy is ignored
        rises.delete();
        s = m_accepts;
        send(8'hC3);
        repeat (20) @(negedge clk);
        #1 tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        #1 tx_valid = 1'b0;
        wait_done();
        chk("busy_ignore_accepts", m_accepts - s, 1);
        chk("busy_ignore_mosi", rises_byte(), 8'hC3);
        chk("busy_ignore_rx", last_rx, 8'hC3);

        // Reset after the third SCK rise aborts the frame
        rises.delete();
        send(8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rises.size() >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("abort_rise_timeout", 0, 1);
        @(negedge clk);
        chk("abort_sck_high_before", SCK, 1);
        #1 reset_ni = 1'b0;
        #1;
        chk("abort_SS", SS, 1);
        chk("abort_SCK", SCK, 0);
        chk("abort_busy", busy_o, 0);
        rxv0 = n_rxv;
        repeat (3) @(negedge clk);
        #1 reset_ni = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_rx_valid", n_rxv - rxv0, 0);
        send(8'h99);
        wait_done();
        chk("after_abort_rx", last_rx, 8'h99);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            mode = 2'($urandom_range(0, 3));
            slave_word = 8'($urandom);
            d = 8'($urandom);
            case (mode)
                2'd0:    exp_rx = d;
                2'd1:    exp_rx = 8'h00;
                2'd2:    exp_rx = 8'hFF;
                default: exp_rx = slave_word;
            endcase
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rises.delete();
            send(d);
            wait_done();
            chk("rand_rx", last_rx, exp_rx);
            chk("rand_mosi", rises_byte(), d);
            if (mode == 2'd3) chk("rand_slave_got", slave_got, d);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
